// File: rtl/packet_serializer_pkg.sv
// Shared command-channel definitions: framing constants, FSM encoding, CRC-8 step.
// Latency: none (declarations and a combinational function only).
// Backpressure: not applicable; used by both the packet serializer and the packet receiver.
package cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;
  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SYNC = 3'd1,
    S_LEN  = 3'd2,
    S_BODY = 3'd3,
    S_CRC  = 3'd4
  } frame_state_t;

  // One byte of MSB-first CRC-8; both ends of the link call this so they cannot drift apart.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/packet_serializer_if.sv
// Request and transmit-byte bundle between command logic, packet_serializer and the UART tx.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready for requests, tx_valid/tx_ready for bytes; PKT_TX_STATS_EN adds counters.
interface packet_serializer_if #(
  parameter int SIZE = 256
);
  logic [8*SIZE-1:0] payload;
  logic [7:0]        pay_len;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic              err_len;
`ifdef PKT_TX_STATS_EN
  logic [15:0]       frame_count;
  logic [15:0]       reject_count;
`endif

  // Requesting side: issues payloads and sinks the byte stream.
  modport master (
    output payload, pay_len, in_valid, tx_ready,
    input  in_ready, tx_data, tx_valid, busy, done, err_len
`ifdef PKT_TX_STATS_EN
    , input frame_count, reject_count
`endif
  );

  // Serializer side.
  modport slave (
    input  payload, pay_len, in_valid, tx_ready,
    output in_ready, tx_data, tx_valid, busy, done, err_len
`ifdef PKT_TX_STATS_EN
    , output frame_count, reject_count
`endif
  );

endinterface

// File: rtl/packet_serializer_crc8_step.sv
// Combinational single-byte CRC-8 update (poly 0x07), reusable by the receiver.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the caller decides when the result is committed.
module crc8_step
  import cmd_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  // Fold one byte into the running CRC.
  always_comb begin
    crc_out = crc8_next(crc_in, data_in);
  end

endmodule

// File: rtl/packet_serializer.sv
// Frames a payload as SYNC, LEN(=payload+1), payload, CRC8 and streams it one byte per cycle.
// Latency: SYNC valid the cycle after acceptance; done pulses the cycle after the CRC byte transfers.
// Backpressure: tx_data/tx_valid hold while tx_ready=0; in_ready low for the whole frame.
// Build option PKT_TX_STATS_EN adds frame_count/reject_count outputs.
module packet_serializer
  import cmd_pkg::*;
#(
  parameter int         SIZE = 256,
  parameter logic [7:0] SYNC = SYNC_BYTE
) (
  input logic               CLK,
  input logic               rst,
  packet_serializer_if.slave bus
);

  // Largest payload that still fits SYNC, LEN and CRC inside SIZE bytes.
  localparam int unsigned MAX_PAY = SIZE - 3;

  frame_state_t         state_q, state_d;
  logic [SIZE-1:0][7:0] pay_q;
  logic [7:0]           len_q;
  logic [7:0]           idx_q, idx_d;
  logic [7:0]           crc_q, crc_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_len_q, err_len_d;
  logic                 in_ready_q, in_ready_d;
  logic                 latch_req;

  logic                 xfer;
  logic                 accept;
  logic                 len_ok;
  logic                 last_byte;
  logic [7:0]           crc_seed;
  logic [7:0]           crc_step_out;

  assign xfer      = tx_valid_q & bus.tx_ready;
  assign accept    = bus.in_valid & in_ready_q;
  assign len_ok    = (bus.pay_len != 8'd0) && (32'(bus.pay_len) <= MAX_PAY);
  assign last_byte = (idx_q == (len_q - 8'd1));
  // The CRC restarts on the LEN byte, so the seed is forced to the init value there.
  assign crc_seed  = (state_q == S_LEN) ? CRC8_INIT : crc_q;

  // The byte currently on tx_data is the one being folded when it transfers.
  crc8_step u_crc (
    .crc_in  (crc_seed),
    .data_in (tx_data_q),
    .crc_out (crc_step_out)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 8'd0;
      crc_q      <= CRC8_INIT;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_len_q  <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      crc_q      <= crc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_len_q  <= err_len_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Capture the request; held for the whole frame so the source may change freely.
  always_ff @(posedge CLK) begin
    if (latch_req) begin
      pay_q <= bus.payload;
      len_q <= bus.pay_len;
    end
  end

  // Frame sequencing: every state advances only on a completed byte transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && len_ok)      state_d = S_SYNC;
      S_SYNC:  if (xfer)                  state_d = S_LEN;
      S_LEN:   if (xfer)                  state_d = S_BODY;
      S_BODY:  if (xfer && last_byte)     state_d = S_CRC;
      S_CRC:   if (xfer)                  state_d = S_IDLE;
      default:                            state_d = S_IDLE;
    endcase
  end

  // Next byte to present, CRC/index updates and status flags.
  always_comb begin
    tx_data_d = tx_data_q;
    idx_d     = idx_q;
    crc_d     = crc_q;
    latch_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept && len_ok) begin
          latch_req = 1'b1;
          tx_data_d = SYNC;
          idx_d     = 8'd0;
          crc_d     = CRC8_INIT;
        end
      end
      S_SYNC: begin
        if (xfer) tx_data_d = len_q + 8'd1;
      end
      S_LEN: begin
        if (xfer) begin
          crc_d     = crc_step_out;
          idx_d     = 8'd0;
          tx_data_d = pay_q[0];
        end
      end
      S_BODY: begin
        if (xfer) begin
          crc_d = crc_step_out;
          if (last_byte) begin
            tx_data_d = crc_step_out;
          end else begin
            idx_d     = idx_q + 8'd1;
            tx_data_d = pay_q[idx_q + 8'd1];
          end
        end
      end
      default: ;
    endcase
    tx_valid_d = (state_d != S_IDLE);
    busy_d     = (state_d != S_IDLE);
    in_ready_d = (state_d == S_IDLE);
    done_d     = (state_q == S_CRC) && xfer;
    err_len_d  = (state_q == S_IDLE) && accept && !len_ok;
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err_len  = err_len_q;
  assign bus.in_ready = in_ready_q;

`ifdef PKT_TX_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] reject_cnt_q;

  // Completed and rejected request counters, wrapping at 16 bits.
  always_ff @(posedge CLK) begin
    if (rst) begin
      frame_cnt_q  <= 16'd0;
      reject_cnt_q <= 16'd0;
    end else begin
      if (done_d)    frame_cnt_q  <= frame_cnt_q + 16'd1;
      if (err_len_d) reject_cnt_q <= reject_cnt_q + 16'd1;
    end
  end

  assign bus.frame_count  = frame_cnt_q;
  assign bus.reject_count = reject_cnt_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/packet_serializer.md
Name: packet_serializer

Overview:
Transmit-side counterpart of the command-channel packet receiver. Takes a payload and its length from the command/response logic, then emits the framed byte stream SYNC, LEN, payload bytes, CRC8 over a ready/valid byte interface toward the UART transmitter. LEN = payload bytes + 1 (it counts the CRC byte). The CRC is CRC-8, polynomial 0x07, init 0x00, taken over the LEN byte and the payload bytes. This framing is bit-compatible with the receiver.

Parameters:
SIZE, 256, maximum frame size in bytes (SYNC+LEN+payload+CRC); payload limit is SIZE-3
SYNC, 8'hAA, frame start byte

Ports:
CLK  input  1  clock
rst  input  1  synchronous, active-high reset
payload  input  8*SIZE  payload bytes; byte k at [8*k +: 8], k=0 sent first; bytes >= pay_len ignored
pay_len  input  8  payload byte count, legal 1..SIZE-3
in_valid  input  1  request to send payload/pay_len
in_ready  output  1  serializer idle, accepts request
tx_data  output  8  outgoing byte
tx_valid  output  1  tx_data valid
tx_ready  input  1  downstream (UART tx) accepts byte
busy  output  1  frame in progress
done  output  1  1-cycle pulse after CRC byte accepted
err_len  output  1  1-cycle pulse: request rejected for illegal pay_len

Behaviour:
- Reset values: in_ready=0, tx_valid=0, tx_data=8'h00, busy=0, done=0, err_len=0, state=S_IDLE, crc=0, idx=0. in_ready rises the first cycle after rst deasserts.
- Request acceptance: in_valid && in_ready at edge t.
  - If pay_len legal: latch payload and pay_len; from t+1, tx_valid=1, tx_data=SYNC, busy=1, in_ready=0.
  - If pay_len==0 or pay_len>SIZE-3: err_len=1 at t+1; nothing transmitted; in_ready stays 1.
- Byte handshake: a byte transfers on tx_valid && tx_ready. tx_data and tx_valid are held stable while tx_ready=0. The next byte is presented the cycle after a transfer, with tx_valid staying high (back-to-back, 1 byte/cycle max).
- States:
  - S_IDLE -> S_SYNC on a legal request.
  - S_SYNC: drives SYNC. On transfer -> S_LEN, tx_data=pay_len+1.
  - S_LEN: on transfer, crc<=crc8_next(0,LEN), idx<=0 -> S_BODY, tx_data=payload[0].
  - S_BODY: on transfer, crc<=crc8_next(crc,payload[idx]). If idx==pay_len-1 -> S_CRC, tx_data=updated crc; else idx+1, next payload byte.
  - S_CRC: on transfer, tx_valid=0, busy=0, done=1 (one cycle), in_ready=1 -> S_IDLE.
- Back-to-back frames: earliest next request is accepted the cycle after done; no SYNC is emitted in the done cycle.
- in_valid while busy is ignored; payload/pay_len are not sampled.
- Reset mid-frame: immediate abort to reset values; partial frame is not completed. The receiver recovers via its CRC/length check.
- Widths: LEN computed in 8 bits; pay_len<=SIZE-3 guarantees no overflow at SIZE=256 (max LEN 254). idx is 8 bits.

Optional Feature:
PKT_TX_STATS_EN:
- Defined: adds outputs frame_count[15:0] and reject_count[15:0], both reset to 0.
  - frame_count increments on each done pulse.
  - reject_count increments on each err_len pulse.
  - Both wrap 0xFFFF -> 0x0000.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package cmd_pkg: SYNC default 8'hAA, CRC8_POLY 8'h07, CRC8_INIT 8'h00, frame state encoding constants, crc8_next function (shared with the receiver so both ends use one definition).
- Natural sub-module: crc8_step (combinational, 8-bit crc in, 8-bit data in, crc out), reusable by the receiver.
- Byte mux from payload bus stays inline.

Test Plan:
- Basic frame: payload bytes {0x01,0x02}, pay_len=2, tx_ready=1 -> stream AA 03 01 02 A6 on 5 consecutive cycles; done pulses once; in_ready returns to 1.
- Backpressure: same request, tx_ready=0 for 3 cycles while LEN is presented -> tx_data holds 0x03 and tx_valid=1 throughout; final stream identical; CRC=0xA6.
- Length errors: pay_len=0, then pay_len=254 (SIZE=256) -> err_len pulse for each, tx_valid never asserts, in_ready stays 1.
- Max frame: pay_len=253, payload byte k=k -> 256 bytes; LEN=0xFE; CRC matches reference model; loopback into the receiver gives valid_packet with no err_crc.
- Reset mid-frame: rst asserted after 4th byte -> next cycle tx_valid=0, busy=0; a new request {0x55}, pay_len=1 afterwards -> AA 02 55 CRC.
- Stats (PKT_TX_STATS_EN): 3 good frames + 1 rejected request -> frame_count=3, reject_count=1; busy-time in_valid pulses are not counted.
